egress_port_arbiter: RTL

//  Per-destination output stage of the 4-port router; one instance per destination port.

---
 rtl/router_pkg.sv | 29 ++
 rtl/rr_picker.sv | 39 +++
 rtl/egress_port_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
// Shared types and constants for the 4-port router egress path.
//   NUM_PORTS   : number of source FIFOs feeding each egress arbiter
//   CNT_W       : width of the per-source starvation counters (limit 1..15)
//   prio_t      : 2-bit programmable priority, 3 = highest
//   src_idx_t   : source index / round-robin pointer
//   flit_t      : address/data pair carried by one flit
//   arb_state_e : output register occupancy (EMPTY / FULL)
// ---------------------------------------------------------------------------
package router_pkg;

   localparam int NUM_PORTS = 4;
   localparam int CNT_W     = 4;

   typedef logic [1:0] prio_t;
   typedef logic [1:0] src_idx_t;

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] data;
   } flit_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin picker over NUM_PORTS requesters. The search
// starts at last_i+1 and wraps, so the most recent winner has lowest
// precedence among the current requesters.
//   req_i       in   NUM_PORTS  candidate mask
//   last_i      in   2          index of the previous winner
//   grant_o     out  NUM_PORTS  one-hot grant (all zero when req_i == 0)
//   grant_idx_o out  2          index of the granted requester
// ---------------------------------------------------------------------------
module rr_picker
   import router_pkg::*;
(
   input  logic [NUM_PORTS-1:0] req_i,
   input  src_idx_t             last_i,
   output logic [NUM_PORTS-1:0] grant_o,
   output src_idx_t             grant_idx_o
);

   src_idx_t idx;
   logic     found;

   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      idx         = '0;
      // Offset NUM_PORTS wraps back to last_i itself, so it is checked last.
      for (int k = 1; k <= NUM_PORTS; k++) begin
         idx = last_i + src_idx_t'(k);
         if (!found && req_i[idx]) begin
            found        = 1'b1;
            grant_o[idx] = 1'b1;
            grant_idx_o  = idx;
         end
      end
   end

endmodule

// File: rtl/egress_port_arbiter.sv
// ---------------------------------------------------------------------------
// egress_port_arbiter
// Per-destination output stage of the 4-port router. Picks one of the source
// FIFO heads (starved sources first, then highest priority, ties broken
// round-robin), pops it and holds it in a one-entry output register.
//   clk        in   1               clock, all state on posedge
//   reset      in   1               asynchronous, active-low reset
//   src_valid  in   NUM_SRC         show-ahead FIFO head valid
//   src_addr   in   NUM_SRC*ADDR_W  head addresses, source i at [i*ADDR_W +: ADDR_W]
//   src_data   in   NUM_SRC*DATA_W  head data, same packing
//   src_pop    out  NUM_SRC         one-hot pop of the winning FIFO
//   prio_wr    in   1               load prio_val into the priority register
//   prio_val   in   8               priority of source i at [2i+1:2i]
//   rd_en      in   1               destination accepts the current flit
//   addr_out   out  ADDR_W          registered flit address
//   data_out   out  DATA_W          registered flit data
//   data_rdy   out  1               output register full (also the FSM state)
//   grant_id   out  2               source index of the registered flit
//
// Handshakes: a source transfer happens on a rising edge where src_valid[i]
// and src_pop[i] are both high; an output transfer happens on a rising edge
// where data_rdy and rd_en are both high. rd_en with data_rdy low is ignored,
// and addr/data/grant_id stay stable while data_rdy is high and rd_en is low.
// ---------------------------------------------------------------------------
module egress_port_arbiter
   import router_pkg::*;
#(
   parameter int NUM_SRC      = 4,
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_SRC-1:0]        src_valid,
   input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   output logic [NUM_SRC-1:0]        src_pop,
   input  logic                      prio_wr,
   input  logic [7:0]                prio_val,
   input  logic                      rd_en,
   output logic [ADDR_W-1:0]         addr_out,
   output logic [DATA_W-1:0]         data_out,
   output logic                      data_rdy,
   output logic [1:0]                grant_id
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   arb_state_e        state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   src_idx_t          grant_q;
   logic [7:0]        prio_q;
   src_idx_t          last_q;
   logic [CNT_W-1:0]  cnt_q [NUM_SRC];
   logic [CNT_W-1:0]  cnt_d [NUM_SRC];

   logic [NUM_SRC-1:0] starved, top_mask, pick_req, win_oh;
   src_idx_t           win_idx;
   prio_t              top_prio;
   logic [ADDR_W-1:0]  win_addr;
   logic [DATA_W-1:0]  win_data;
   logic               load;

   // Candidate selection: starved requesters override priority entirely.
   always_comb begin
      starved  = '0;
      top_mask = '0;
      top_prio = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         starved[i] = src_valid[i] && (cnt_q[i] == LIMIT);
         if (src_valid[i] && (prio_q[2*i +: 2] > top_prio))
            top_prio = prio_q[2*i +: 2];
      end
      for (int i = 0; i < NUM_SRC; i++)
         top_mask[i] = src_valid[i] && (prio_q[2*i +: 2] == top_prio);
      pick_req = (|starved) ? starved : top_mask;
   end

   rr_picker u_rr_picker (
      .req_i       (pick_req),
      .last_i      (last_q),
      .grant_o     (win_oh),
      .grant_idx_o (win_idx)
   );

   // Qualified by reset so no pop escapes while reset is asserted.
   assign load    = reset && (|src_valid) && ((state_q == EMPTY) || rd_en);
   assign src_pop = load ? win_oh : '0;

   always_comb begin
      win_addr = '0;
      win_data = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (win_idx == src_idx_t'(i)) begin
            win_addr = src_addr[i*ADDR_W +: ADDR_W];
            win_data = src_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // A source that is not requesting loses its starvation history at once.
   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         if (!src_valid[i])
            cnt_d[i] = '0;
         else if (load && (win_idx == src_idx_t'(i)))
            cnt_d[i] = '0;
         else if (load && (cnt_q[i] != LIMIT))
            cnt_d[i] = cnt_q[i] + 1'b1;
         else
            cnt_d[i] = cnt_q[i];
      end
   end

   // Output register FSM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= EMPTY;
         addr_q  <= '0;
         data_q  <= '0;
         grant_q <= '0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (load) begin
                  state_q <= FULL;
                  addr_q  <= win_addr;
                  data_q  <= win_data;
                  grant_q <= win_idx;
               end
            end
            FULL: begin
               if (rd_en) begin
                  if (load) begin
                     addr_q  <= win_addr;
                     data_q  <= win_data;
                     grant_q <= win_idx;
                  end else begin
                     state_q <= EMPTY;
                  end
               end
            end
            default: state_q <= EMPTY;
         endcase
      end
   end

   // Arbitration state. A priority write only affects later arbitrations.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prio_q <= 8'h00;
         last_q <= 2'd3;
         for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
      end else begin
         if (prio_wr) prio_q <= prio_val;
         if (load)    last_q <= win_idx;
         for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign addr_out = addr_q;
   assign data_out = data_q;
   assign data_rdy = (state_q == FULL);
   assign grant_id = grant_q;

endmodule
